// File: rtl/booth_recoder_seq.sv
// booth_recoder_seq: sequential radix-4 Booth recoder streaming one select code per group over valid/ready
module booth_recoder_seq #(
  parameter int WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [WIDTH-1:0]                   mplr,
  output logic                               busy,
  output logic                               sel_valid,
  input  logic                               sel_ready,
  output logic [2:0]                         sel_out,
  output logic [$clog2(WIDTH/2)-1:0]         grp_idx,
  output logic                               last,
  output logic                               done
);
  localparam int NGRP = WIDTH / 2;
  localparam int GW = $clog2(NGRP);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH:0] sreg_q, sreg_d;
  logic [GW-1:0] cnt_q, cnt_d;
  logic [2:0] code;
  assign busy = state_q != IDLE;
  assign sel_valid = state_q == SCAN;
  assign done = state_q == DONE;
  assign grp_idx = cnt_q;
  assign last = sel_valid && cnt_q == GW'(NGRP - 1);
  assign code = 3'd3 + 3'(sreg_q[1]) + 3'(sreg_q[0]) - {1'b0, sreg_q[2], 1'b0};
  assign sel_out = sel_valid ? code : 3'd3;
  always_comb begin
    state_d = state_q;
    sreg_d = sreg_q;
    cnt_d = cnt_q;
    if (state_q == IDLE && start) begin
      state_d = SCAN;
      sreg_d = {mplr, 1'b0};
      cnt_d = '0;
    end else if (state_q == SCAN && sel_ready) begin
      sreg_d = sreg_q >> 2;
      cnt_d = last ? '0 : cnt_q + 1'b1;
      state_d = last ? DONE : SCAN;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sreg_q <= sreg_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_booth_recoder_seq.sv
// tb_booth_recoder_seq: scoreboard bench for booth_recoder_seq
module tb_booth_recoder_seq;
  localparam int WIDTH = 16;
  localparam int NGRP = 8;
  localparam int GW = 3;
  logic clk = 1'b0;
  logic rst, start, sel_ready, busy, sel_valid, last, done;
  logic [WIDTH-1:0] mplr;
  logic [2:0] sel_out;
  logic [GW-1:0] grp_idx;
  typedef struct {
    int code;
    int idx;
    int lst;
  } exp_t;
  exp_t exq[$];
  int sumq[$];
  int vectors = 0;
  int miscompares = 0;
  int acc = 0;
  always #5 clk = ~clk;
  booth_recoder_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mplr(mplr),
    .busy(busy),
    .sel_valid(sel_valid),
    .sel_ready(sel_ready),
    .sel_out(sel_out),
    .grp_idx(grp_idx),
    .last(last),
    .done(done)
  );
  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic int ref_code(input logic [2:0] t);
    case (t)
      3'b000, 3'b111: return 3;
      3'b001, 3'b010: return 4;
      3'b011: return 5;
      3'b100: return 1;
      default: return 2;
    endcase
  endfunction
  task automatic push_exp(input logic [15:0] m, input logic [31:0] codes, input int ngr,
                          input bit use_model, input bit sum);
    logic [16:0] s;
    exp_t e;
    s = {m, 1'b0};
    for (int i = 0; i < ngr; i++) begin
      e.code = use_model ? ref_code(s[2:0]) : int'(codes[4*i+:4]);
      e.idx = i;
      e.lst = (i == NGRP - 1) ? 1 : 0;
      exq.push_back(e);
      s = s >> 2;
    end
    if (sum) sumq.push_back(int'($signed(m)));
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst) acc = 0;
    else if (!sel_valid) begin
      check("idle_sel", int'(sel_out), 3);
      check("idle_last", int'(last), 0);
    end else if (sel_ready) begin
      if (exq.size() == 0) check("extra_code", 1, 0);
      else begin
        e = exq.pop_front();
        check("sel_out", int'(sel_out), e.code);
        check("grp_idx", int'(grp_idx), e.idx);
        check("last", int'(last), e.lst);
        acc += (int'(sel_out) - 3) <<< (2 * int'(grp_idx));
        if (last) begin
          if (sumq.size() == 0) check("extra_sum", 1, 0);
          else check("sum", acc, sumq.pop_front());
          acc = 0;
        end
      end
    end
  end
  task automatic run(input logic [15:0] m, input logic [31:0] codes, input bit use_model,
                     input int stall, input int exp_lat, input bit spur);
    int n;
    bit seen;
    int first;
    n = 0;
    seen = 0;
    first = use_model ? ref_code({m[1:0], 1'b0}) : int'(codes[3:0]);
    push_exp(m, codes, NGRP, use_model, 1);
    @(posedge clk);
    #1;
    start = 1;
    mplr = m;
    sel_ready = stall < 0 ? 1'($urandom_range(0, 1)) : (stall == 0);
    @(posedge clk);
    #1;
    start = 0;
    mplr = 16'($urandom);
    if (stall < 0) sel_ready = 1'($urandom_range(0, 1));
    while (n < 200 && !seen) begin
      @(negedge clk);
      n++;
      if (n <= stall) begin
        check("stall_valid", int'(sel_valid), 1);
        check("stall_sel", int'(sel_out), first);
        check("stall_grp", int'(grp_idx), 0);
      end
      if (done) begin
        seen = 1;
        check("busy_done", int'(busy), 1);
      end else begin
        @(posedge clk);
        #1;
        start = spur && n == 2;
        if (start) mplr = 16'h1234;
        sel_ready = stall < 0 ? 1'($urandom_range(0, 1)) : (n >= stall);
      end
    end
    check("done_seen", int'(seen), 1);
    if (exp_lat >= 0) check("done_lat", n, exp_lat);
    @(posedge clk);
    #1;
    start = 0;
    @(negedge clk);
    check("done_pulse", int'(done), 0);
    check("busy_idle", int'(busy), 0);
  endtask
  task automatic reset_mid();
    push_exp(16'h0001, 32'h33333334, 4, 0, 0);
    @(posedge clk);
    #1;
    start = 1;
    mplr = 16'h0001;
    sel_ready = 1;
    @(posedge clk);
    #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk);
    check("rst_grp", int'(grp_idx), 4);
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check("rst_valid", int'(sel_valid), 0);
    check("rst_sel", int'(sel_out), 3);
    check("rst_busy", int'(busy), 0);
    check("rst_grpidx", int'(grp_idx), 0);
    repeat (3) begin
      check("rst_no_done", int'(done), 0);
      @(negedge clk);
    end
    check("rst_q_empty", exq.size(), 0);
  endtask
  initial begin
    rst = 1;
    start = 0;
    sel_ready = 0;
    mplr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy0", int'(busy), 0);
    check("rst_valid0", int'(sel_valid), 0);
    check("rst_sel0", int'(sel_out), 3);
    check("rst_grp0", int'(grp_idx), 0);
    check("rst_last0", int'(last), 0);
    check("rst_done0", int'(done), 0);
    @(posedge clk);
    #1;
    rst = 0;
    run(16'h0001, 32'h33333334, 0, 0, 9, 0);
    run(16'hFFFF, 32'h33333332, 0, 0, 9, 0);
    run(16'h8000, 32'h13333333, 0, 0, 9, 0);
    run(16'h0003, 32'h33333342, 0, 0, 9, 0);
    run(16'h5555, 32'h44444444, 0, 0, 9, 0);
    run(16'h0003, 32'h33333342, 0, 3, 12, 0);
    run(16'h0001, 32'h33333334, 0, 0, 9, 1);
    reset_mid();
    run(16'hFFFF, 32'h33333332, 0, 0, 9, 0);
    run(16'h7FFF, 32'h0, 1, -1, -1, 0);
    run(16'h8000, 32'h0, 1, -1, -1, 0);
    for (int i = 0; i < 1500; i++) run(16'($urandom), 32'h0, 1, -1, -1, 0);
    check("final_codes_left", exq.size(), 0);
    check("final_sums_left", sumq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
